// File: rtl/pulse_stretch_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and
// window counter sizing.
package pulse_stretch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   function automatic int cnt_width(input int high_cyc, input int low_cyc);
      return $clog2(((high_cyc > low_cyc) ? high_cyc : low_cyc) + 1);
   endfunction

endpackage

// File: rtl/pulse_stretch_rise.sv
// Two-flop synchronizer plus rising-edge detector for a raw asynchronous level.
// Only compiled when PULSE_STRETCH_SYNC_EN is defined.
`ifdef PULSE_STRETCH_SYNC_EN
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic i_level,
   output logic o_rise
);

   logic r_d1;
   logic r_d2;
   logic r_d3;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_d1 <= 1'b0;
         r_d2 <= 1'b0;
         r_d3 <= 1'b0;
      end else begin
         r_d1 <= i_level;
         r_d2 <= r_d1;
         r_d3 <= r_d2;
      end
   end

   assign o_rise = r_d2 & ~r_d3;

endmodule
`endif

// File: rtl/pulse_stretch.sv
// Stretches single-cycle events into HIGH_CYC-wide windows separated by LOW_CYC gaps,
// queueing overlapping events. Define PULSE_STRETCH_SYNC_EN to accept a raw async level.
module pulse_stretch
   import pulse_stretch_pkg::*;
#(
   parameter int HIGH_CYC = 4,
   parameter int LOW_CYC  = 2,
   parameter int PEND_W   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_pulse,
   output logic              o_level,
   output logic              o_busy,
   output logic [PEND_W-1:0] o_pend,
   output logic              o_ovf
);

   localparam int CW = cnt_width(HIGH_CYC, LOW_CYC);
   localparam logic [CW-1:0]     HIGH_LOAD = CW'(HIGH_CYC - 1);
   localparam logic [CW-1:0]     LOW_LOAD  = CW'(LOW_CYC - 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = '1;

   state_t            r_state;
   logic [CW-1:0]     r_cnt;
   logic [PEND_W-1:0] r_pend;
   logic              r_ovf;
   logic              r_level;
   logic              r_busy;

   state_t            w_next;
   logic [CW-1:0]     w_cnt;
   logic [PEND_W-1:0] w_pend;
   logic              w_drop;
   logic              w_event;

`ifdef PULSE_STRETCH_SYNC_EN
   rise_detect u_rise (
      .clk     (clk),
      .rst     (rst),
      .i_level (i_pulse),
      .o_rise  (w_event)
   );
`else
   assign w_event = i_pulse;
`endif

   // Counter counts down from load-1 so the final cycle of a phase is r_cnt == 0.
   always_comb begin
      w_next = r_state;
      w_cnt  = r_cnt;
      w_pend = r_pend;
      w_drop = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_event) begin
               w_next = HIGH;
               w_cnt  = HIGH_LOAD;
            end
         end
         HIGH: begin
            if (w_event) begin
               if (r_pend == PEND_MAX) w_drop = 1'b1;
               else                    w_pend = r_pend + 1'b1;
            end
            if (r_cnt == '0) begin
               w_next = LOW;
               w_cnt  = LOW_LOAD;
            end else begin
               w_cnt = r_cnt - 1'b1;
            end
         end
         LOW: begin
            if (r_cnt != '0) begin
               w_cnt = r_cnt - 1'b1;
               if (w_event) begin
                  if (r_pend == PEND_MAX) w_drop = 1'b1;
                  else                    w_pend = r_pend + 1'b1;
               end
            end else if (r_pend != '0) begin
               // One queued event starts now; a simultaneous new event takes its slot.
               w_next = HIGH;
               w_cnt  = HIGH_LOAD;
               if (!w_event) w_pend = r_pend - 1'b1;
            end else if (w_event) begin
               w_next = HIGH;
               w_cnt  = HIGH_LOAD;
            end else begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
            w_cnt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pend  <= '0;
         r_ovf   <= 1'b0;
         r_level <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt;
         r_pend  <= w_pend;
         r_level <= (w_next == HIGH);
         r_busy  <= (w_next != IDLE);
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   assign o_level = r_level;
   assign o_busy  = r_busy;
   assign o_pend  = r_pend;
   assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed self-checking bench for pulse_stretch; cycle n is the interval after
// the n-th rising edge following reset release.
module tb_pulse_stretch;

   logic       clk;
   logic       rst;
   logic       i_pulse;
   logic       o_level;
   logic       o_busy;
   logic [2:0] o_pend;
   logic       o_ovf;

   int cyc;
   int checks;
   int failures;

   pulse_stretch #(
      .HIGH_CYC (4),
      .LOW_CYC  (2),
      .PEND_W   (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_pulse (i_pulse),
      .o_level (o_level),
      .o_busy  (o_busy),
      .o_pend  (o_pend),
      .o_ovf   (o_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic advance();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Advance to cycle n, driving i_pulse = p in every newly entered cycle.
   task automatic applyStimulus(input int n, input logic p);
      while (cyc < n) begin
         advance();
         i_pulse = p;
      end
   endtask

   task automatic doReset();
      rst     = 1'b1;
      i_pulse = 1'b0;
      advance();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic checkOutput(input string tag, input logic expLevel, input logic expBusy,
                              input logic [2:0] expPend, input logic expOvf);
      checks++;
      assert (o_level === expLevel) else begin
         failures++;
         $error("FAIL %s cyc=%0d o_level got %0b want %0b", tag, cyc, o_level, expLevel);
      end
      checks++;
      assert (o_busy === expBusy) else begin
         failures++;
         $error("FAIL %s cyc=%0d o_busy got %0b want %0b", tag, cyc, o_busy, expBusy);
      end
      checks++;
      assert (o_pend === expPend) else begin
         failures++;
         $error("FAIL %s cyc=%0d o_pend got %0d want %0d", tag, cyc, o_pend, expPend);
      end
      checks++;
      assert (o_ovf === expOvf) else begin
         failures++;
         $error("FAIL %s cyc=%0d o_ovf got %0b want %0b", tag, cyc, o_ovf, expOvf);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      rst      = 1'b1;
      i_pulse  = 1'b0;

`ifdef PULSE_STRETCH_SYNC_EN
      doReset();
      checkOutput("sync_reset", 1'b0, 1'b0, 3'd0, 1'b0);
      applyStimulus(9, 1'b0);
      applyStimulus(12, 1'b1);
      checkOutput("sync_c12", 1'b0, 1'b0, 3'd0, 1'b0);
      applyStimulus(13, 1'b1);
      checkOutput("sync_c13", 1'b1, 1'b1, 3'd0, 1'b0);
      applyStimulus(16, 1'b1);
      checkOutput("sync_c16", 1'b1, 1'b1, 3'd0, 1'b0);
      applyStimulus(17, 1'b1);
      checkOutput("sync_c17", 1'b0, 1'b1, 3'd0, 1'b0);
      applyStimulus(19, 1'b1);
      checkOutput("sync_c19", 1'b0, 1'b0, 3'd0, 1'b0);
      applyStimulus(40, 1'b1);
      checkOutput("sync_c40", 1'b0, 1'b0, 3'd0, 1'b0);
      applyStimulus(41, 1'b0);
`else
      // Single event
      doReset();
      checkOutput("reset", 1'b0, 1'b0, 3'd0, 1'b0);
      applyStimulus(10, 1'b0);
      i_pulse = 1'b1;
      checkOutput("single_c10", 1'b0, 1'b0, 3'd0, 1'b0);
      applyStimulus(11, 1'b0);
      checkOutput("single_c11", 1'b1, 1'b1, 3'd0, 1'b0);
      applyStimulus(14, 1'b0);
      checkOutput("single_c14", 1'b1, 1'b1, 3'd0, 1'b0);
      applyStimulus(15, 1'b0);
      checkOutput("single_c15", 1'b0, 1'b1, 3'd0, 1'b0);
      applyStimulus(16, 1'b0);
      checkOutput("single_c16", 1'b0, 1'b1, 3'd0, 1'b0);
      applyStimulus(17, 1'b0);
      checkOutput("single_c17", 1'b0, 1'b0, 3'd0, 1'b0);

      // Queued events at 10, 12, 13
      doReset();
      applyStimulus(10, 1'b0);
      i_pulse = 1'b1;
      applyStimulus(12, 1'b0);
      i_pulse = 1'b1;
      applyStimulus(13, 1'b1);
      checkOutput("queue_c13", 1'b1, 1'b1, 3'd1, 1'b0);
      applyStimulus(14, 1'b0);
      checkOutput("queue_c14", 1'b1, 1'b1, 3'd2, 1'b0);
      applyStimulus(16, 1'b0);
      checkOutput("queue_c16", 1'b0, 1'b1, 3'd2, 1'b0);
      applyStimulus(17, 1'b0);
      checkOutput("queue_c17", 1'b1, 1'b1, 3'd1, 1'b0);
      applyStimulus(20, 1'b0);
      checkOutput("queue_c20", 1'b1, 1'b1, 3'd1, 1'b0);
      applyStimulus(21, 1'b0);
      checkOutput("queue_c21", 1'b0, 1'b1, 3'd1, 1'b0);
      applyStimulus(23, 1'b0);
      checkOutput("queue_c23", 1'b1, 1'b1, 3'd0, 1'b0);
      applyStimulus(26, 1'b0);
      checkOutput("queue_c26", 1'b1, 1'b1, 3'd0, 1'b0);
      applyStimulus(27, 1'b0);
      checkOutput("queue_c27", 1'b0, 1'b1, 3'd0, 1'b0);
      applyStimulus(29, 1'b0);
      checkOutput("queue_c29", 1'b0, 1'b0, 3'd0, 1'b0);

      // Event in the final LOW cycle with nothing queued
      doReset();
      applyStimulus(10, 1'b0);
      i_pulse = 1'b1;
      applyStimulus(16, 1'b0);
      i_pulse = 1'b1;
      checkOutput("lastlow_c16", 1'b0, 1'b1, 3'd0, 1'b0);
      applyStimulus(17, 1'b0);
      checkOutput("lastlow_c17", 1'b1, 1'b1, 3'd0, 1'b0);
      applyStimulus(20, 1'b0);
      checkOutput("lastlow_c20", 1'b1, 1'b1, 3'd0, 1'b0);
      applyStimulus(21, 1'b0);
      checkOutput("lastlow_c21", 1'b0, 1'b1, 3'd0, 1'b0);

      // Held input saturates the queue
      doReset();
      applyStimulus(9, 1'b0);
      applyStimulus(19, 1'b1);
      checkOutput("sat_c19", 1'b1, 1'b1, 3'd7, 1'b0);
      applyStimulus(20, 1'b1);
      checkOutput("sat_c20", 1'b1, 1'b1, 3'd7, 1'b1);
      applyStimulus(25, 1'b1);
      applyStimulus(40, 1'b0);
      checkOutput("sat_c40", 1'b0, 1'b1, 3'd5, 1'b1);

      // Drain without reset; o_ovf must remain sticky
      for (int k = 0; k < 200 && (o_busy !== 1'b0 || o_pend !== 3'd0); k++) begin
         applyStimulus(cyc + 1, 1'b0);
      end
      checkOutput("drain_idle", 1'b0, 1'b0, 3'd0, 1'b1);

      // Reset mid-window with queued events and a coincident pulse
      cyc = 0;
      applyStimulus(7, 1'b0);
      applyStimulus(10, 1'b1);
      applyStimulus(12, 1'b0);
      checkOutput("rstmid_c12", 1'b1, 1'b1, 3'd2, 1'b1);
      rst     = 1'b1;
      i_pulse = 1'b1;
      applyStimulus(13, 1'b0);
      rst = 1'b0;
      checkOutput("rstmid_c13", 1'b0, 1'b0, 3'd0, 1'b0);
      applyStimulus(14, 1'b0);
      checkOutput("rstmid_c14", 1'b0, 1'b0, 3'd0, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
